// File: rtl/program_counter_pkg.sv
// Shared types for the program counter: FSM states, active-low JK cell
// encodings and the per-bit load decode helper.
package program_counter_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

    // {j, k}, both active low
    typedef logic [1:0] jk_t;

    localparam jk_t JK_TOGGLE = 2'b00;
    localparam jk_t JK_SET    = 2'b01;
    localparam jk_t JK_RESET  = 2'b10;
    localparam jk_t JK_HOLD   = 2'b11;

    function automatic jk_t jk_load(input logic b);
        return b ? JK_SET : JK_RESET;
    endfunction

endpackage

// File: rtl/program_counter_jk_ff_r.sv
// JK flip-flop with active-low J/K and asynchronous active-low clear to 0.
module jk_ff_r
    import program_counter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                JK_TOGGLE: q <= ~q;
                JK_SET:    q <= 1'b1;
                JK_RESET:  q <= 1'b0;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter built from JK cells: RUN/HALT FSM, per-bit J/K decode
// with a synchronous carry chain, and a registered wrap pulse.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic             wrap,
    output logic             halted
);

    pc_state_e              state, state_nxt;
    logic                   run;
    logic                   inc_op;
    logic                   wrap_d;
    jk_t       [WIDTH-1:0]  jk;

    assign run    = (state == RUN);
    assign halted = (state == HALT);

    // An increment only counts when nothing of higher priority claims the cycle.
    assign inc_op = !clr && run && !load && inc_en;
    assign wrap_d = inc_op && (&pc);

    always_comb begin
        logic carry;
        jk    = '{default: JK_HOLD};
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (clr)
                jk[i] = JK_RESET;
            else if (run && load)
                jk[i] = jk_load(load_val[i]);
            else if (inc_op && carry)
                jk[i] = JK_TOGGLE;
            carry = carry & pc[i];
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff_r u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (jk[i][1]),
            .k     (jk[i][0]),
            .q     (pc[i])
        );
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = RUN;
        else if (run && halt)
            state_nxt = HALT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            wrap  <= wrap_d;
        end
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning counter/address width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port inc_en  input  1  advance count by one on the next edge.
REQ-005 SHALL have port load  input  1  replace count with load_val on the next edge.
REQ-006 SHALL have port load_val  input  WIDTH  jump/branch target.
REQ-007 SHALL have port clr  input  1  synchronous clear to zero; also exits HALT.
REQ-008 SHALL have port halt  input  1  request entry to HALT state.
REQ-009 SHALL have port pc  output  WIDTH  current count, registered.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse, registered.
REQ-011 SHALL have port halted  output  1  high while in HALT state.

Function
REQ-012 SHALL implement a two-state FSM: RUN and HALT.
REQ-013 In RUN, per-edge priority SHALL be: clr > load > inc_en > hold.
REQ-014 clr SHALL set pc to 0 on the next edge, in either state.
REQ-015 load (no clr) in RUN SHALL set pc to load_val on the next edge; inc_en is ignored that cycle.
REQ-016 inc_en alone in RUN SHALL set pc to (pc+1) mod 2^WIDTH on the next edge.
REQ-017 With clr, load and inc_en all low, pc SHALL hold.
REQ-018 wrap SHALL be 1 for exactly the cycle following an increment from all-ones to zero, and 0 otherwise, including after load of 0 or clr.
REQ-019 halt high in RUN with clr low SHALL move the FSM to HALT on the next edge; any load/inc_en in that same cycle still takes effect.
REQ-020 In HALT, load and inc_en SHALL be ignored and pc SHALL hold.
REQ-021 HALT SHALL be left only via clr (to RUN, pc=0) or reset; halt input is ignored while in HALT.
REQ-022 clr and halt high together SHALL result in RUN with pc=0.
REQ-023 halted SHALL equal (state == HALT), with no combinational path from inputs.
REQ-024 Each pc bit SHALL be held in a JK flip-flop cell with active-low J/K encoding: J=0,K=0 toggle; J=0,K=1 set; J=1,K=0 reset; J=1,K=1 hold.
REQ-025 Increment SHALL be synchronous: bit i toggles iff inc_en and all bits below i are 1; load and clr drive the set/reset encodings per bit.
REQ-026 Latency from any control input to pc/halted/wrap SHALL be exactly one clock edge.

Reset
REQ-027 rst_n low SHALL immediately, without a clock, force pc=0, wrap=0, halted=0, state=RUN.
REQ-028 Deassertion of rst_n SHALL take effect on the next rising clk edge; a clock edge coincident with deassertion performs no count.
REQ-029 Reset asserted mid-increment or mid-load SHALL override that operation.

Structure
REQ-030 A shared package SHALL hold the FSM state typedef (RUN, HALT) and the JK encoding constants (JK_TOGGLE, JK_SET, JK_RESET, JK_HOLD).
REQ-031 One sub-module, jk_ff_r (a JK flip-flop with asynchronous active-low reset to 0, same active-low J/K encoding), SHALL be instantiated WIDTH times via generate.
REQ-032 FSM, wrap register and per-bit J/K decode SHALL live in program_counter itself.

Verification
REQ-033 Reset, then inc_en high for 300 cycles -> pc steps 0,1,...,255,0,...; wrap high only in the cycle pc reads 0x00 after 0xFF.
REQ-034 pc=0x10, load=1, load_val=0xA5, inc_en=1 -> next pc=0xA5; then inc_en only -> 0xA6.
REQ-035 pc=0x20, halt=1 with inc_en=1 -> pc=0x21, halted=1; then load 0x55 and inc_en for 5 cycles -> pc stays 0x21; clr -> pc=0x00, halted=0.
REQ-036 clr=1, load=1 (0x77), halt=1 in one cycle -> pc=0x00, halted=0, wrap=0.
REQ-037 pc=0xFF counting, rst_n pulled low between edges -> pc=0, wrap=0 immediately; release, inc_en -> 0x01 after second edge.
REQ-038 load 0x00 from pc=0xFF -> pc=0x00, wrap stays 0.
